// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator behind a two-entry skid buffer.
// Define IMM_GEN_CSR_EN to decode SYSTEM csr*i zimm as the CSR format.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);
  typedef enum logic [2:0] {F_NONE, F_I, F_S, F_B, F_U, F_J, F_SHAMT, F_CSR} fmt_t;
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_t            fmt;
    logic            illegal;
  } entry_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_sh;
  logic            tgt_en;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, sh5, sh6;
  entry_t          dec, out_e, skid_e;
  logic            out_v, skid_v, acc, drain, load_out, load_skid;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign is_sh = f3 == 3'b001 || f3 == 3'b101;
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign sh5   = XLEN'(in_instr[24:20]);
  assign sh6   = XLEN'(in_instr[25:20]);

  always_comb begin
    dec    = '0;
    tgt_en = 1'b0;
    case (opc)
      7'b0000011, 7'b1100111: begin
        dec.imm = imm_i;
        dec.fmt = F_I;
      end
      7'b0010011: begin
        dec.imm     = is_sh ? (XLEN == 64 ? sh6 : sh5) : imm_i;
        dec.fmt     = is_sh ? F_SHAMT : F_I;
        dec.illegal = is_sh && XLEN == 32 && in_instr[25];
      end
      7'b0011011: begin
        // word-sized shifts only exist on RV64 and always take a 5-bit amount
        dec.imm     = XLEN == 64 ? (is_sh ? sh5 : imm_i) : '0;
        dec.fmt     = XLEN == 64 ? (is_sh ? F_SHAMT : F_I) : F_NONE;
        dec.illegal = XLEN == 64 ? is_sh && in_instr[25] : 1'b1;
      end
      7'b0100011: begin
        dec.imm = imm_s;
        dec.fmt = F_S;
      end
      7'b1100011: begin
        dec.imm = imm_b;
        dec.fmt = F_B;
        tgt_en  = 1'b1;
      end
      7'b1101111: begin
        dec.imm = imm_j;
        dec.fmt = F_J;
        tgt_en  = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        dec.imm = imm_u;
        dec.fmt = F_U;
        tgt_en  = opc[5] == 1'b0;
      end
      7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
        if (f3[2] && f3[1:0] != 2'b00) begin
          dec.imm = XLEN'(in_instr[19:15]);
          dec.fmt = F_CSR;
        end
`endif
      end
      7'b0110011, 7'b0111011: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.target = tgt_en ? in_pc + dec.imm : '0;
  end

  assign acc       = in_valid && !skid_v;
  assign drain     = out_v && out_ready;
  assign load_out  = acc && (!out_v || drain);
  assign load_skid = acc && out_v && !drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_e  <= '0;
      skid_e <= '0;
    end else begin
      out_v  <= (out_v && !drain) || skid_v || acc;
      skid_v <= load_skid || (skid_v && !drain);
      out_e  <= drain && skid_v ? skid_e : load_out ? dec : out_e;
      skid_e <= load_skid ? dec : skid_e;
    end
  end

  assign in_ready    = !skid_v;
  assign out_valid   = out_v;
  assign out_imm     = out_e.imm;
  assign out_target  = out_e.target;
  assign out_fmt     = out_e.fmt;
  assign out_illegal = out_e.illegal;
endmodule
